fixed_point_div: RTL and testbench

Sequential signed fixed-point divider, the inverse of `fixed_point_mul`, in the same Q(INTEGER_PART_WIDTH).(FRACTIONAL_PART_WIDTH) two's-complement format. It computes `result = a / b` with a restoring shift-subtract loop, producing one quotient bit per cycle. It uses the same `start`/`done` handshake as the multiplier, so the plotter datapath can drive either unit with the same sequencing.

---
 rtl/fixed_point_div.sv | 143 ++++++++++++++
 tb/tb_fixed_point_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider (restoring shift-subtract, one quotient bit per cycle).
// Optional macro FIXED_POINT_DIV_SATURATE_EN selects saturating instead of wrapping overflow.
module fixed_point_div #(
    parameter int INTEGER_PART_WIDTH    = 3,
    parameter int FRACTIONAL_PART_WIDTH = 2,
    localparam int N = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int W = N + FRACTIONAL_PART_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] result
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

    state_t         state_reg, state_next;
    logic           sign_reg, sign_next;
    logic [N-1:0]   mag_b_reg, mag_b_next;
    logic [W-1:0]   dividend_reg, dividend_next;
    logic [N:0]     rem_reg, rem_next;
    logic [W-1:0]   q_reg, q_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           done_reg, done_next;
    logic [N-1:0]   result_reg, result_next;
`ifdef FIXED_POINT_DIV_SATURATE_EN
    logic           zero_ab_reg, zero_ab_next;
    localparam logic [W-1:0] Q_POS_LIM = W'((2 ** (N - 1)) - 1);
    localparam logic [W-1:0] Q_NEG_LIM = W'(2 ** (N - 1));
`endif

    logic [N-1:0]   abs_a, abs_b;
    logic [N:0]     rem_shift, rem_sub;
    logic           rem_ge;
    logic           neg;
    logic [N-1:0]   wrapped;

    // Magnitudes are N-bit unsigned so the most negative code maps to 2^(N-1).
    assign abs_a     = a[N-1] ? (~a + 1'b1) : a;
    assign abs_b     = b[N-1] ? (~b + 1'b1) : b;
    assign rem_shift = {rem_reg[N-1:0], dividend_reg[W-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_b_reg};
    assign rem_sub   = rem_shift - {1'b0, mag_b_reg};
    assign neg       = sign_reg && (q_reg != '0);
    assign wrapped   = neg ? (~q_reg[N-1:0] + 1'b1) : q_reg[N-1:0];

    always_comb begin
        state_next    = state_reg;
        sign_next     = sign_reg;
        mag_b_next    = mag_b_reg;
        dividend_next = dividend_reg;
        rem_next      = rem_reg;
        q_next        = q_reg;
        cnt_next      = cnt_reg;
        done_next     = done_reg;
        result_next   = result_reg;
`ifdef FIXED_POINT_DIV_SATURATE_EN
        zero_ab_next  = zero_ab_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = DIV;
                    sign_next     = a[N-1] ^ b[N-1];
                    mag_b_next    = abs_b;
                    dividend_next = {abs_a, {FRACTIONAL_PART_WIDTH{1'b0}}};
                    rem_next      = '0;
                    q_next        = '0;
                    cnt_next      = '0;
                    done_next     = 1'b0;
`ifdef FIXED_POINT_DIV_SATURATE_EN
                    zero_ab_next  = (a == '0) && (b == '0);
`endif
                end
            end
            DIV: begin
                rem_next      = rem_ge ? rem_sub : rem_shift;
                q_next        = {q_reg[W-2:0], rem_ge};
                dividend_next = dividend_reg << 1;
                cnt_next      = cnt_reg + 1'b1;
                if (cnt_reg == CW'(W - 1))
                    state_next = FINISH;
            end
            FINISH: begin
                state_next  = IDLE;
                done_next   = 1'b1;
`ifdef FIXED_POINT_DIV_SATURATE_EN
                // 0/0 would otherwise saturate on the all-ones quotient.
                if (zero_ab_reg)
                    result_next = '0;
                else if (!neg && (q_reg > Q_POS_LIM))
                    result_next = {1'b0, {(N-1){1'b1}}};
                else if (neg && (q_reg > Q_NEG_LIM))
                    result_next = {1'b1, {(N-1){1'b0}}};
                else
                    result_next = wrapped;
`else
                result_next = wrapped;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sign_reg     <= 1'b0;
            mag_b_reg    <= '0;
            dividend_reg <= '0;
            rem_reg      <= '0;
            q_reg        <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b1;
            result_reg   <= '0;
`ifdef FIXED_POINT_DIV_SATURATE_EN
            zero_ab_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            sign_reg     <= sign_next;
            mag_b_reg    <= mag_b_next;
            dividend_reg <= dividend_next;
            rem_reg      <= rem_next;
            q_reg        <= q_next;
            cnt_reg      <= cnt_next;
            done_reg     <= done_next;
            result_reg   <= result_next;
`ifdef FIXED_POINT_DIV_SATURATE_EN
            zero_ab_reg  <= zero_ab_next;
`endif
        end
    end

    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_fixed_point_div.sv
// Self-checking bench for fixed_point_div (Q3.2) against an arithmetic reference model.
module tb_fixed_point_div;

    localparam int N = 5;
    localparam int F = 2;
    localparam int W = N + F;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                done;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic signed [N-1:0] result;

    int total = 0;
    int bad   = 0;

    fixed_point_div #(.INTEGER_PART_WIDTH(3), .FRACTIONAL_PART_WIDTH(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .done   (done),
        .a      (a),
        .b      (b),
        .result (result)
    );

    always #5 clk = ~clk;

    // Quotient magnitude by integer division, then sign and overflow policy.
    function automatic logic [N-1:0] model(input int av, input int bv);
        int ma, mb, q, r;
        bit neg;
        ma = (av < 0) ? -av : av;
        mb = (bv < 0) ? -bv : bv;
        q = (mb == 0) ? (2 ** W) - 1 : (ma * (2 ** F)) / mb;
        neg = ((av < 0) != (bv < 0)) && (q != 0);
`ifdef FIXED_POINT_DIV_SATURATE_EN
        if (ma == 0 && mb == 0)          r = 0;
        else if (!neg && q > 15)         r = 15;
        else if (neg && q > 16)          r = -16;
        else                             r = neg ? -q : q;
`else
        r = neg ? -q : q;
`endif
        return r[N-1:0];
    endfunction

    // Called at a negedge; returns at the negedge where done is seen high.
    task automatic run_div(input int av, input int bv, input bit noisy,
                           output logic [N-1:0] res, output bit timed_out);
        a = N'(av);
        b = N'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (noisy) begin
                a = N'($urandom);
                b = N'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b1 || result !== '0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: done=%b result=%0d, want done=1 result=0", i, done, result);
            end
        end
    endtask

    task automatic test_directed;
        int ta[12] = '{6, 4, 1, -1, -6, -8, 6, 15, -16, 5, -5, 0};
        int tb_[12] = '{4, 8, 3, 3, 4, 4, -4, 1, 2, 0, 0, 0};
`ifdef FIXED_POINT_DIV_SATURATE_EN
        int te[12] = '{6, 2, 1, 31, 26, 24, 26, 15, 16, 15, 16, 0};
`else
        int te[12] = '{6, 2, 1, 31, 26, 24, 26, 28, 0, 31, 1, 31};
`endif
        logic [N-1:0] res;
        bit to;
        for (int i = 0; i < 12; i++) begin
            run_div(ta[i], tb_[i], 1'b0, res, to);
            total++;
            if (to || res !== N'(te[i])) begin
                bad++;
                $display("FAIL directed a=%0d b=%0d: got %0d (timeout=%0d), want %0d", ta[i], tb_[i], res, to, te[i]);
            end else
                $display("a: %0d, b: %0d, result: %0d", ta[i], tb_[i], res);
        end
    endtask

    task automatic test_latency;
        a = 5'sd6;
        b = 5'sd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL latency_busy cycle %0d: done=%b, want 0", i, done);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || result !== 5'd6) begin
            bad++;
            $display("FAIL latency_done: done=%b result=%0d, want done=1 result=6", done, result);
        end else
            $display("a: 6, b: 4, result: %0d", result);
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] res;
        bit to;
        a = 5'sd7;
        b = 5'sd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || result !== '0) begin
            bad++;
            $display("FAIL reset_mid: done=%b result=%0d, want done=1 result=0", done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        total++;
        if (done !== 1'b1 || result !== '0) begin
            bad++;
            $display("FAIL reset_no_partial: done=%b result=%0d, want done=1 result=0", done, result);
        end
        run_div(7, 2, 1'b0, res, to);
        total++;
        if (to || res !== model(7, 2)) begin
            bad++;
            $display("FAIL after_reset a=7 b=2: got %0d (timeout=%0d), want %0d", res, to, model(7, 2));
        end else
            $display("a: 7, b: 2, result: %0d", res);
    endtask

    // All operand pairs, back to back, with random start pulses and operand churn while busy.
    task automatic test_sweep;
        logic [N-1:0] res;
        logic [N-1:0] exp_v;
        bit to;
        for (int ai = -16; ai < 16; ai++) begin
            for (int bi = -16; bi < 16; bi++) begin
                run_div(ai, bi, 1'b1, res, to);
                exp_v = model(ai, bi);
                total++;
                if (to || res !== exp_v) begin
                    bad++;
                    $display("FAIL sweep a=%0d b=%0d: got %0d (timeout=%0d), want %0d", ai, bi, res, to, exp_v);
                end else
                    $display("a: %0d, b: %0d, result: %0d", ai, bi, res);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_latency;
        test_reset_mid;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
